// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, pipelined imem request/response
// handshake with up to DEPTH requests in flight, and a DEPTH-entry FIFO of
// {pc, inst} pairs feeding decode. Redirects flush the FIFO and turn every
// outstanding response into one that is silently dropped on arrival.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [XLEN-1:0]          if_pc,
  output logic [XLEN-1:0]          if_inst,
  output logic [$clog2(DEPTH):0]   fq_count,
  output logic                     proto_err
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  // Occupancy (count + inflight) needs one extra bit so the sum cannot wrap.
  localparam logic [CntW:0] DepthOcc = (CntW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  // Architectural state
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [CntW-1:0]  r_count;
  logic [CntW-1:0]  r_inflight;
  logic [CntW-1:0]  r_drop;
  logic             r_proto_err;
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW-1:0] r_wr_ptr;
  logic [XLEN-1:0]  r_pc_mem   [DEPTH];
  logic [XLEN-1:0]  r_inst_mem [DEPTH];

  // Next-state values
  logic [XLEN-1:0]  w_fetch_pc_nxt;
  logic [XLEN-1:0]  w_rsp_pc_nxt;
  logic [CntW-1:0]  w_count_nxt;
  logic [CntW-1:0]  w_inflight_nxt;
  logic [CntW-1:0]  w_drop_nxt;
  logic             w_proto_err_nxt;
  logic [AddrW-1:0] w_rd_ptr_nxt;
  logic [AddrW-1:0] w_wr_ptr_nxt;

  // Datapath decodes
  logic [CntW:0]    w_occ;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp_take;
  logic             w_rsp_stray;
  logic             w_rsp_drop;
  logic             w_push;
  logic             w_if_valid;
  logic             w_pop;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_unused_redirect_lsb;

  assign w_occ         = {1'b0, r_count} + {1'b0, r_inflight};
  // Issue only while a FIFO slot is reserved for every outstanding response,
  // which is what keeps pushes from ever overflowing the buffer.
  assign w_req_valid   = !redirect_valid && (w_occ < DepthOcc);
  assign w_req_fire    = reset && w_req_valid && imem_req_ready;

  // A response only counts if something is actually outstanding.
  assign w_rsp_take    = imem_rsp_valid && (r_inflight != '0);
  assign w_rsp_stray   = imem_rsp_valid && (r_inflight == '0);
  assign w_rsp_drop    = w_rsp_take && (r_drop != '0);
  assign w_push        = w_rsp_take && (r_drop == '0) && !redirect_valid;

  assign w_if_valid    = (r_count != '0) && !redirect_valid;
  assign w_pop         = w_if_valid && if_ready;

  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  // Low target bits are forced to zero; they are intentionally ignored.
  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  // Next-state computation; a redirect overrides every other update.
  always_comb begin
    w_fetch_pc_nxt  = r_fetch_pc;
    w_rsp_pc_nxt    = r_rsp_pc;
    w_count_nxt     = r_count;
    w_inflight_nxt  = r_inflight;
    w_drop_nxt      = r_drop;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_proto_err_nxt = r_proto_err | w_rsp_stray;

    if (redirect_valid) begin
      w_fetch_pc_nxt = w_redirect_pc;
      w_rsp_pc_nxt   = w_redirect_pc;
      w_count_nxt    = '0;
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
      // A response landing in the redirect cycle is consumed and discarded;
      // everything still outstanding afterwards is stale.
      w_inflight_nxt = r_inflight - CntW'(w_rsp_take);
      w_drop_nxt     = w_inflight_nxt;
    end else begin
      if (w_req_fire) begin
        w_fetch_pc_nxt = r_fetch_pc + PcStep;
      end
      if (w_push) begin
        w_rsp_pc_nxt = r_rsp_pc + PcStep;
        w_wr_ptr_nxt = r_wr_ptr + AddrW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + AddrW'(1);
      end
      w_count_nxt    = r_count + CntW'(w_push) - CntW'(w_pop);
      w_inflight_nxt = r_inflight + CntW'(w_req_fire) - CntW'(w_rsp_take);
      w_drop_nxt     = r_drop - CntW'(w_rsp_drop);
    end
  end

  // Control and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_count     <= '0;
      r_inflight  <= '0;
      r_drop      <= '0;
      r_proto_err <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_rsp_pc    <= w_rsp_pc_nxt;
      r_count     <= w_count_nxt;
      r_inflight  <= w_inflight_nxt;
      r_drop      <= w_drop_nxt;
      r_proto_err <= w_proto_err_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
    end
  end

  // FIFO storage; contents need no reset because validity comes from r_count.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
      r_inst_mem[r_wr_ptr] <= imem_rsp_data;
    end
  end

  // Outputs are held at zero (address at RESET_PC) while reset is asserted.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = RESET_PC;
    if_valid       = 1'b0;
    if_pc          = '0;
    if_inst        = '0;
    fq_count       = '0;
    proto_err      = 1'b0;
    if (reset) begin
      imem_req_valid = w_req_valid;
      imem_req_addr  = r_fetch_pc;
      if_valid       = w_if_valid;
      if_pc          = r_pc_mem[r_rd_ptr];
      if_inst        = r_inst_mem[r_rd_ptr];
      fq_count       = r_count;
      proto_err      = r_proto_err;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. The reference model keeps the fetch
// stream as plain queues: one of outstanding requests (address, stale flag,
// due cycle) and one of delivered {pc, inst} entries. The bench also plays
// the in-order instruction memory.
module tb_fetch_queue;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [2:0]  fq_count;
  logic        proto_err;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .fq_count       (fq_count),
    .proto_err      (proto_err)
  );

  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        oq[$];
  ent_t        fq[$];
  logic [31:0] m_fetch = RESET_PC;
  bit          m_proto = 1'b0;
  bit          rst_n   = 1'b0;
  int          lat     = 1;   // 0 selects a random latency of 1..4 per request
  int          cyc     = 0;
  int          checks  = 0;
  int          errors  = 0;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model across the rising edge.
  task automatic cycle(input bit rdv, input logic [31:0] rdpc, input bit rrdy,
                       input bit ifr, input bit rogue);
    bit          e_req;
    bit          e_ifv;
    bit          rsp;
    logic [31:0] rdata;
    ent_t        e;
    req_t        r;

    reset          = rst_n;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    imem_req_ready = rrdy;
    if_ready       = ifr;
    rsp            = 1'b0;
    rdata          = $urandom;
    if (rst_n) begin
      if (rogue && oq.size() == 0) begin
        rsp = 1'b1;
      end else if (oq.size() != 0 && oq[0].due <= cyc) begin
        rsp   = 1'b1;
        rdata = memf(oq[0].addr);
      end
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;

    e_req = rst_n && !rdv && (fq.size() + oq.size() < int'(DEPTH));
    e_ifv = rst_n && !rdv && (fq.size() != 0);

    #4;
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    if (!rst_n) chk("req_addr_rst", imem_req_addr, RESET_PC);
    else if (e_req) chk("req_addr", imem_req_addr, m_fetch);
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("fq_count", 32'(fq_count), rst_n ? 32'(fq.size()) : 32'd0);
    chk("proto_err", 32'(proto_err), 32'(rst_n && m_proto));
    if (e_ifv) begin
      chk("if_pc", if_pc, fq[0].pc);
      chk("if_inst", if_inst, fq[0].inst);
    end
    if (!rst_n) begin
      chk("if_pc_rst", if_pc, 32'd0);
      chk("if_inst_rst", if_inst, 32'd0);
    end

    @(posedge clk);
    if (!rst_n) begin
      oq.delete();
      fq.delete();
      m_fetch = RESET_PC;
      m_proto = 1'b0;
    end else begin
      if (e_ifv && ifr) e = fq.pop_front();
      if (rsp) begin
        if (oq.size() == 0) begin
          m_proto = 1'b1;
        end else begin
          r = oq.pop_front();
          if (!r.stale && !rdv) begin
            e.pc   = r.addr;
            e.inst = rdata;
            fq.push_back(e);
          end
        end
      end
      if (rdv) begin
        fq.delete();
        foreach (oq[i]) oq[i].stale = 1'b1;
        m_fetch = {rdpc[31:2], 2'b00};
      end else if (e_req && rrdy) begin
        r.addr  = m_fetch;
        r.stale = 1'b0;
        r.due   = cyc + ((lat == 0) ? int'($urandom_range(1, 4)) : lat);
        oq.push_back(r);
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then a steady one-cycle-latency stream.
    rst_n = 1'b0;
    lat   = 1;
    repeat (2) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (12) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Decode stalled from reset: fill to DEPTH, hold head, then drain.
    rst_n = 1'b0;
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (10) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Latency 3 with several requests outstanding, then redirect to 0x100.
    lat = 3;
    repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
    repeat (12) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Redirect coinciding with a response and a would-be pop.
    lat = 1;
    repeat (5) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0180, 1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Misaligned target, then back-to-back redirects.
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Stray response with a full FIFO and nothing in flight; sticky error.
    repeat (8) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Fetch PC wrap past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic: backpressure, stalls, redirects, rare resets.
    lat = 0;
    repeat (1500) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
